lsmitll_buff_array: RTL and testbench
=====================================

# lsmitll_buff_array

Clocked, parametrised multi-channel successor to the single-bit RSFQ buffer behavioural cell. It carries NCH independent toggle-encoded SFQ pulse channels, where each pulse is any transition on `a[i]`. Each channel has a programmable delay in clock ticks, a startup blanking window and an optional hold-time violation checker. It sits in cycle-based co-simulation benches, where the clock is the simulation time quantum (1 tick = 1 ps nominal), and it replaces chains of discrete buffer cells.

## Interface
Parameters:
- `NCH`, 4: number of independent channels (≥1).
- `DELAY`, 6: input-to-output latency in ticks (≥1).
- `HOLD`, 4: hold window in ticks; 0 disables checking.
- `BEGIN`, 8: startup blanking ticks after reset release (≥0).

Ports:
- `clk`, input, 1: simulation time-quantum clock; all logic on rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `a`, input, NCH: toggle-encoded input pulses, one bit per channel.
- `q`, output, NCH: toggle-encoded output pulses, registered.
- `ready`, output, 1: high once blanking has elapsed.
- `viol`, output, NCH: sticky hold-violation flags. Present only with `LSMITLL_BUFF_HOLD_CHK_EN`.

## Operation
- Edge detect per channel: `a_d[i]` registers `a[i]` every cycle; event = `a[i] ^ a_d[i]` at the sampling edge.
- Reset (`rst_n`=0 at an edge): `q`=0, `ready`=0, `viol`=0, delay pipelines cleared, hold counters idle, blank counter = BEGIN, and `a_d` <= `a`. The effect of `a_d` <= `a` is that levels held through reset never generate an event.
- Blanking: for the first BEGIN edges after release, events are detected (`a_d` tracks) but discarded and do not arm the hold window. `ready` rises at the edge where the counter reaches 0. With BEGIN=0, `ready`=1 at the first post-reset edge.
- Accepted event: enters a DELAY-deep one-bit shift register per channel. When it exits, `q[i]` <= `!q[i]`.
- Hold window: an accepted event at edge k arms a per-channel down-counter. Any event at edge j with j−k < HOLD is a violation, handled per Configuration.
- A dropped (violating) event does not re-arm the window. An accepted event re-arms it.
- Channels are fully independent. Simultaneous events on several channels are all processed in the same cycle.
- Reset mid-operation: in-flight events are lost, and no toggle appears after release for pre-reset pulses.

## Timing
- Event sampled at edge k gives a `q[i]` toggle visible after edge k+DELAY. Fixed latency, no dependence on other channels.
- Back-to-back events (j−k=1) with HOLD≤1 both propagate, so `q` toggles on consecutive cycles.
- Pipeline holds up to DELAY outstanding events per channel. There is no overflow condition, because at most one event enters per cycle.
- `ready` latency: BEGIN edges after the first edge with `rst_n`=1.

## Configuration
- `LSMITLL_BUFF_HOLD_CHK_EN` defined:
  - `viol` port exists.
  - A violating event is dropped, so it never reaches the pipeline and `q` does not toggle for it.
  - `viol[i]` sets at the violating edge and stays set until reset.
- Not defined:
  - No `viol` port and no hold counters.
  - HOLD is ignored and every post-blanking event propagates.

## Test plan
- Reset then latency: NCH=4, DELAY=6, BEGIN=8. After `ready`, toggle `a[0]` at edge 20 → `q[0]` 0→1 after edge 26; other `q` bits stay 0.
- Blanking: toggle `a[1]` at edge 3 after release (BEGIN=8) → no `q[1]` toggle ever. An `a[1]` toggle at edge 12 → `q[1]` toggles at edge 18.
- Hold violation (macro on, HOLD=4): `a[2]` toggles at edges 30 and 32 → one `q[2]` toggle at 36; `viol[2]`=1 from edge 32. A further toggle at 35 is accepted (35−30≥4) → `q[2]` toggles at 41.
- Macro off, same stimulus as the hold-violation test → `q[2]` toggles at 36 and 38.
- Simultaneous and back-to-back: all four `a` bits toggle at edge 40, and `a[3]` toggles again at 41 (HOLD=0) → all `q` toggle at 46, and `q[3]` toggles again at 47.
- Reset mid-flight: toggle `a[0]` at 50, assert `rst_n`=0 at 53 for 2 edges → `q`=0 and no toggle at 56. `ready` returns after BEGIN edges, and `viol` is cleared.

Source files
------------

// File: rtl/lsmitll_buff_array_if.sv
// Pulse bus for lsmitll_buff_array: toggle-encoded inputs/outputs, ready, and
// sticky hold-violation flags when LSMITLL_BUFF_HOLD_CHK_EN is defined.
interface lsmitll_buff_array_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] a;
    logic [NCH-1:0] q;
    logic           ready;
`ifdef LSMITLL_BUFF_HOLD_CHK_EN
    logic [NCH-1:0] viol;

    modport master (output a, input q, input ready, input viol);
    modport slave  (input a, output q, output ready, output viol);
`else
    modport master (output a, input q, input ready);
    modport slave  (input a, output q, output ready);
`endif
endinterface

// File: rtl/lsmitll_buff_array.sv
// Multi-channel clocked RSFQ buffer: per-channel edge detect, fixed delay line,
// startup blanking; hold checker/dropping enabled by LSMITLL_BUFF_HOLD_CHK_EN.
module lsmitll_buff_lane #(
    parameter int DELAY = 6,
    parameter int HOLD  = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic a_i,
    output logic q_o
`ifdef LSMITLL_BUFF_HOLD_CHK_EN
    ,
    output logic viol_o
`endif
);
    logic             a_d_q;
    logic [DELAY-1:0] pipe_q;
    logic [DELAY-1:0] pipe_d;
    logic             q_q;
    logic             ev;
    logic             acc;

    assign ev = a_i ^ a_d_q;

`ifdef LSMITLL_BUFF_HOLD_CHK_EN
    // Counter is loaded with HOLD-1 on acceptance; nonzero means inside the window.
    localparam int            HW  = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] ARM = HW'((HOLD > 0) ? HOLD - 1 : 0);

    logic [HW-1:0] hold_q;
    logic          viol_q;
    logic          hit;

    assign hit = ev && en_i && (hold_q != '0);
    assign acc = ev && en_i && !hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            viol_q <= 1'b0;
        end else begin
            if (acc)
                hold_q <= ARM;
            else if (hold_q != '0)
                hold_q <= hold_q - HW'(1);
            if (hit)
                viol_q <= 1'b1;
        end
    end

    assign viol_o = viol_q;
`else
    logic unused_hold;
    assign unused_hold = (HOLD != 0);
    assign acc         = ev && en_i;
`endif

    assign pipe_d = DELAY'({pipe_q, acc});

    always_ff @(posedge clk) begin
        // Tracking a through reset keeps held levels from looking like pulses.
        a_d_q <= a_i;
        if (!rst_n) begin
            pipe_q <= '0;
            q_q    <= 1'b0;
        end else begin
            pipe_q <= pipe_d;
            q_q    <= q_q ^ pipe_q[DELAY-1];
        end
    end

    assign q_o = q_q;
endmodule

module lsmitll_buff_array #(
    parameter int NCH   = 4,
    parameter int DELAY = 6,
    parameter int HOLD  = 4,
    parameter int BEGIN = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    lsmitll_buff_array_if.slave bus
);
    localparam int BW = (BEGIN > 0) ? $clog2(BEGIN + 1) : 1;

    logic [BW-1:0]  blank_q, blank_d;
    logic           ready_q, ready_d;
    logic           en;
    logic [NCH-1:0] q_w;

    always_comb begin
        blank_d = blank_q;
        if (blank_q != '0)
            blank_d = blank_q - BW'(1);
        ready_d = (blank_q <= BW'(1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= BW'(BEGIN);
            ready_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
            ready_q <= ready_d;
        end
    end

    // Events sampled while the counter is still nonzero are discarded.
    assign en = (blank_q == '0);

`ifdef LSMITLL_BUFF_HOLD_CHK_EN
    logic [NCH-1:0] viol_w;
    assign bus.viol = viol_w;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        lsmitll_buff_lane #(
            .DELAY (DELAY),
            .HOLD  (HOLD)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .en_i   (en),
            .a_i    (bus.a[i]),
            .q_o    (q_w[i])
`ifdef LSMITLL_BUFF_HOLD_CHK_EN
            ,
            .viol_o (viol_w[i])
`endif
        );
    end

    assign bus.q     = q_w;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_lsmitll_buff_array.sv
// Bench for lsmitll_buff_array: table-driven stimulus, event scoreboard model,
// and hand-derived spot checks; adapts to LSMITLL_BUFF_HOLD_CHK_EN.
module tb_lsmitll_buff_array;
    localparam int NCH   = 4;
    localparam int DELAY = 6;
    localparam int HOLD  = 4;
    localparam int BEGIN = 8;
`ifdef LSMITLL_BUFF_HOLD_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lsmitll_buff_array_if #(.NCH(NCH)) bus ();

    lsmitll_buff_array #(
        .NCH(NCH), .DELAY(DELAY), .HOLD(HOLD), .BEGIN(BEGIN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct { int cyc; logic [NCH-1:0] tog; } stim_t;
    typedef struct { int cyc; logic [NCH-1:0] q; logic ready; } spot_t;
    typedef struct { int due; int ch; } sb_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_n;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %0h want %0h", nm, cur_n, act, exp);
        end
    endtask

    // Edge n: n<=0 and 53..54 are reset edges; edge 1 and 55 are first released edges.
    stim_t stim[] = '{
        '{3, 4'b0010}, '{12, 4'b0010}, '{20, 4'b0001},
        '{30, 4'b0100}, '{32, 4'b0100}, '{35, 4'b0100},
        '{40, 4'b1111}, '{41, 4'b1000}, '{50, 4'b0001}, '{70, 4'b1000}
    };

    spot_t spot[] = '{
        '{0, 4'b0000, 1'b0}, '{7, 4'b0000, 1'b0}, '{8, 4'b0000, 1'b1},
        '{17, 4'b0000, 1'b1}, '{18, 4'b0010, 1'b1}, '{26, 4'b0011, 1'b1},
        '{36, 4'b0111, 1'b1},
`ifdef LSMITLL_BUFF_HOLD_CHK_EN
        '{38, 4'b0111, 1'b1}, '{41, 4'b0011, 1'b1},
        '{46, 4'b1100, 1'b1}, '{47, 4'b1100, 1'b1},
`else
        '{38, 4'b0011, 1'b1}, '{41, 4'b0111, 1'b1},
        '{46, 4'b1000, 1'b1}, '{47, 4'b0000, 1'b1},
`endif
        '{53, 4'b0000, 1'b0}, '{56, 4'b0000, 1'b0}, '{61, 4'b0000, 1'b0},
        '{62, 4'b0000, 1'b1}, '{76, 4'b1000, 1'b1}
    };

    // Scoreboard model state
    sb_t            sb[$];
    logic [NCH-1:0] m_q, m_viol, m_ad, ev;
    logic           m_ready;
    int             rel;
    int             last_acc[NCH];

    initial begin
        bus.a = '0;
        rst_n = 1'b0;
        m_ad  = '0;
        for (int n = -2; n <= 80; n++) begin
            cur_n = n;
            rst_n = !(n <= 0 || n == 53 || n == 54);
            foreach (stim[s])
                if (stim[s].cyc == n) bus.a = bus.a ^ stim[s].tog;

            if (!rst_n) begin
                m_q = '0; m_viol = '0; m_ready = 1'b0; rel = 0;
                sb.delete();
                for (int c = 0; c < NCH; c++) last_acc[c] = -1000;
            end else begin
                rel++;
                while (sb.size() > 0 && sb[0].due == n) begin
                    m_q[sb[0].ch] = ~m_q[sb[0].ch];
                    void'(sb.pop_front());
                end
                ev = bus.a ^ m_ad;
                for (int c = 0; c < NCH; c++) begin
                    if (ev[c] && rel > BEGIN) begin
                        if (CHK && (n - last_acc[c] < HOLD)) begin
                            m_viol[c] = 1'b1;
                        end else begin
                            sb.push_back(sb_t'{n + DELAY, c});
                            last_acc[c] = n;
                        end
                    end
                end
                m_ready = (rel >= BEGIN);
            end
            m_ad = bus.a;

            @(posedge clk);
            #1;
            chk("q", 32'(bus.q), 32'(m_q));
            chk("ready", 32'(bus.ready), 32'(m_ready));
`ifdef LSMITLL_BUFF_HOLD_CHK_EN
            chk("viol", 32'(bus.viol), 32'(m_viol));
            if (n == 31) chk("viol_pre", 32'(bus.viol), 32'h0);
            if (n == 32) chk("viol_set", 32'(bus.viol), 32'h4);
            if (n == 41) chk("viol_b2b", 32'(bus.viol), 32'hc);
            if (n == 53) chk("viol_rst", 32'(bus.viol), 32'h0);
`endif
            foreach (spot[s])
                if (spot[s].cyc == n) begin
                    chk("spot_q", 32'(bus.q), 32'(spot[s].q));
                    chk("spot_ready", 32'(bus.ready), 32'(spot[s].ready));
                end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
